// File: rtl/frame_scan_counter_if.sv
// rtl/frame_scan_counter_if.sv - control and position bundle for frame_scan_counter
interface frame_scan_counter_if #(
    parameter int COL_BITS = 11,
    parameter int ROW_BITS = 11
);
    logic                start;
    logic                en_count;
    logic                restart;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                eol;
    logic                eof;
    logic                border;
    logic                busy;
    logic                done;

    modport master (
        output start, en_count, restart,
        input  col, row, eol, eof, border, busy, done
    );

    modport slave (
        input  start, en_count, restart,
        output col, row, eol, eof, border, busy, done
    );
endinterface

// File: rtl/frame_scan_counter.sv
// rtl/frame_scan_counter.sv - raster position counter with line/frame/border flags
module frame_scan_counter #(
    parameter int COL_BITS = 11,
    parameter int ROW_BITS = 11,
    parameter int WIDTH    = 1024,
    parameter int HEIGHT   = 768,
    parameter int RADIUS   = 1,
    parameter int WRAP     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_scan_counter_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    // Limits sized to the counter widths; WIDTH-1 always fits even when WIDTH == 2^COL_BITS.
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(HEIGHT - 1);
    localparam logic [COL_BITS-1:0] COL_LO   = COL_BITS'(RADIUS);
    localparam logic [COL_BITS-1:0] COL_HI   = COL_BITS'(WIDTH - 1 - RADIUS);
    localparam logic [ROW_BITS-1:0] ROW_LO   = ROW_BITS'(RADIUS);
    localparam logic [ROW_BITS-1:0] ROW_HI   = ROW_BITS'(HEIGHT - 1 - RADIUS);

    state_t              state_q, state_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic                done_q, done_d;
    logic                busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        if (bus.restart) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
                RUN: begin
                    if (bus.en_count) begin
                        if (col_q != COL_LAST) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (row_q != ROW_LAST) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                row_d  = '0;
                                done_d = 1'b1;
                                if (WRAP == 0) state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags decode only registered state so there is no input-to-output path.
    assign busy       = (state_q == RUN);
    assign bus.busy   = busy;
    assign bus.col    = col_q;
    assign bus.row    = row_q;
    assign bus.done   = done_q;
    assign bus.eol    = busy && (col_q == COL_LAST);
    assign bus.eof    = busy && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign bus.border = busy && ((col_q < COL_LO) || (col_q > COL_HI) ||
                                 (row_q < ROW_LO) || (row_q > ROW_HI));
endmodule

// File: tb/tb_frame_scan_counter.sv
// tb/tb_frame_scan_counter.sv - directed bench for frame_scan_counter, 4x3 frame, radius 1
module tb_frame_scan_counter;
    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    frame_scan_counter_if #(.COL_BITS(3), .ROW_BITS(2)) if0 ();
    frame_scan_counter_if #(.COL_BITS(3), .ROW_BITS(2)) if1 ();

    frame_scan_counter #(.COL_BITS(3), .ROW_BITS(2), .WIDTH(4), .HEIGHT(3), .RADIUS(1), .WRAP(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    frame_scan_counter #(.COL_BITS(3), .ROW_BITS(2), .WIDTH(4), .HEIGHT(3), .RADIUS(1), .WRAP(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    task automatic cycle0(input logic s, input logic e, input logic r);
        @(negedge clk);
        if0.start = s; if0.en_count = e; if0.restart = r;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle1(input logic s, input logic e, input logic r);
        @(negedge clk);
        if1.start = s; if1.en_count = e; if1.restart = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        compared++; if (if0.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", if0.busy); end
        compared++; if (if0.col !== 3'd0 || if0.row !== 2'd0) begin mismatched++; $display("FAIL reset_pos got %0d,%0d want 0,0", if0.col, if0.row); end
        compared++; if ({if0.eol, if0.eof, if0.border, if0.done} !== 4'b0) begin mismatched++; $display("FAIL reset_flags got %b want 0000", {if0.eol, if0.eof, if0.border, if0.done}); end
        compared++; if (if1.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy1 got %b want 0", if1.busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_scan;
        int c, r;
        logic exp_b;
        cycle0(1, 0, 0);
        compared++; if (if0.busy !== 1'b1 || if0.col !== 3'd0 || if0.row !== 2'd0) begin mismatched++; $display("FAIL scan_start got busy=%b %0d,%0d want 1 0,0", if0.busy, if0.col, if0.row); end
        for (int k = 1; k <= 12; k++) begin
            c = (k - 1) % 4; r = (k - 1) / 4;
            exp_b = !((c == 1 || c == 2) && r == 1);
            compared++; if (if0.eol !== (c == 3)) begin mismatched++; $display("FAIL scan_eol at %0d,%0d got %b want %b", c, r, if0.eol, (c == 3)); end
            compared++; if (if0.eof !== (c == 3 && r == 2)) begin mismatched++; $display("FAIL scan_eof at %0d,%0d got %b", c, r, if0.eof); end
            compared++; if (if0.border !== exp_b) begin mismatched++; $display("FAIL scan_border at %0d,%0d got %b want %b", c, r, if0.border, exp_b); end
            cycle0(0, 1, 0);
            if (k < 12) begin
                compared++; if (if0.col !== 3'(k % 4) || if0.row !== 2'(k / 4) || if0.busy !== 1'b1 || if0.done !== 1'b0) begin
                    mismatched++; $display("FAIL scan_step%0d got %0d,%0d busy=%b done=%b want %0d,%0d 1 0", k, if0.col, if0.row, if0.busy, if0.done, k % 4, k / 4); end
            end else begin
                compared++; if (if0.col !== 3'd0 || if0.row !== 2'd0 || if0.busy !== 1'b0 || if0.done !== 1'b1) begin
                    mismatched++; $display("FAIL scan_end got %0d,%0d busy=%b done=%b want 0,0 0 1", if0.col, if0.row, if0.busy, if0.done); end
            end
        end
        cycle0(0, 1, 0);
        compared++; if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.col !== 3'd0) begin mismatched++; $display("FAIL scan_idle got done=%b busy=%b col=%0d want 0 0 0", if0.done, if0.busy, if0.col); end
        cycle0(0, 0, 0);
    endtask

    task automatic test_wrap;
        int pulses = 0;
        int first = 0;
        int second = 0;
        cycle1(1, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            cycle1(0, 1, 0);
            compared++; if (if1.busy !== 1'b1) begin mismatched++; $display("FAIL wrap_busy step%0d got %b want 1", k, if1.busy); end
            if (if1.done === 1'b1) begin
                pulses++;
                if (pulses == 1) first = k; else second = k;
            end
        end
        compared++; if (pulses !== 2) begin mismatched++; $display("FAIL wrap_pulses got %0d want 2", pulses); end
        compared++; if (first !== 12 || second - first !== 12) begin mismatched++; $display("FAIL wrap_spacing got %0d,%0d want 12,24", first, second); end
        compared++; if (if1.col !== 3'd0 || if1.row !== 2'd0) begin mismatched++; $display("FAIL wrap_pos got %0d,%0d want 0,0", if1.col, if1.row); end
        cycle1(0, 0, 0);
    endtask

    task automatic test_toggle;
        cycle0(1, 0, 0);
        compared++; if (if0.border !== 1'b1) begin mismatched++; $display("FAIL tog_border00 got %b want 1", if0.border); end
        cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd1 || if0.border !== 1'b1) begin mismatched++; $display("FAIL tog_10 got col=%0d border=%b want 1 1", if0.col, if0.border); end
        cycle0(0, 0, 0);
        compared++; if (if0.col !== 3'd1 || if0.row !== 2'd0) begin mismatched++; $display("FAIL tog_hold got %0d,%0d want 1,0", if0.col, if0.row); end
        cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd2) begin mismatched++; $display("FAIL tog_20 got col=%0d want 2", if0.col); end
        repeat (3) cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd1 || if0.row !== 2'd1 || if0.border !== 1'b0) begin mismatched++; $display("FAIL tog_11 got %0d,%0d border=%b want 1,1 0", if0.col, if0.row, if0.border); end
        cycle0(0, 0, 0);
        cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd2 || if0.row !== 2'd1 || if0.border !== 1'b0) begin mismatched++; $display("FAIL tog_21 got %0d,%0d border=%b want 2,1 0", if0.col, if0.row, if0.border); end
    endtask

    task automatic test_restart;
        cycle0(1, 1, 1);
        compared++; if (if0.col !== 3'd0 || if0.row !== 2'd0 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            mismatched++; $display("FAIL restart got %0d,%0d busy=%b done=%b want 0,0 0 0", if0.col, if0.row, if0.busy, if0.done); end
        cycle0(0, 0, 0);
    endtask

    task automatic test_async_reset;
        cycle0(1, 0, 0);
        repeat (7) cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd3 || if0.row !== 2'd1 || if0.eol !== 1'b1) begin mismatched++; $display("FAIL areset_pre got %0d,%0d eol=%b want 3,1 1", if0.col, if0.row, if0.eol); end
        #2;
        rst_n = 1'b0;
        #1;
        compared++; if ({if0.busy, if0.eol, if0.eof, if0.border, if0.done, if0.col, if0.row} !== 10'b0) begin
            mismatched++; $display("FAIL areset_clear got busy=%b eol=%b col=%0d row=%0d want all 0", if0.busy, if0.eol, if0.col, if0.row); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle0(0, 1, 0);
            compared++; if (if0.busy !== 1'b0 || if0.col !== 3'd0) begin mismatched++; $display("FAIL areset_idle%0d got busy=%b col=%0d want 0 0", k, if0.busy, if0.col); end
        end
        cycle0(1, 0, 0);
        compared++; if (if0.busy !== 1'b1 || if0.col !== 3'd0 || if0.row !== 2'd0) begin mismatched++; $display("FAIL areset_restart got busy=%b %0d,%0d want 1 0,0", if0.busy, if0.col, if0.row); end
    endtask

    task automatic test_start_in_run;
        repeat (9) cycle0(0, 1, 0);
        compared++; if (if0.col !== 3'd1 || if0.row !== 2'd2) begin mismatched++; $display("FAIL sir_pos got %0d,%0d want 1,2", if0.col, if0.row); end
        cycle0(1, 0, 0);
        compared++; if (if0.col !== 3'd1 || if0.row !== 2'd2 || if0.busy !== 1'b1) begin mismatched++; $display("FAIL sir_hold got %0d,%0d busy=%b want 1,2 1", if0.col, if0.row, if0.busy); end
        cycle0(1, 1, 0);
        compared++; if (if0.col !== 3'd2 || if0.row !== 2'd2) begin mismatched++; $display("FAIL sir_adv got %0d,%0d want 2,2", if0.col, if0.row); end
        cycle0(0, 1, 0);
        compared++; if (if0.eof !== 1'b1 || if0.eol !== 1'b1) begin mismatched++; $display("FAIL sir_eof got eof=%b eol=%b want 1 1", if0.eof, if0.eol); end
        cycle0(0, 1, 0);
        compared++; if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.col !== 3'd0 || if0.row !== 2'd0) begin
            mismatched++; $display("FAIL sir_done got done=%b busy=%b %0d,%0d want 1 0 0,0", if0.done, if0.busy, if0.col, if0.row); end
        cycle0(0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        if0.start = 1'b0; if0.en_count = 1'b0; if0.restart = 1'b0;
        if1.start = 1'b0; if1.en_count = 1'b0; if1.restart = 1'b0;
        test_reset;
        test_full_scan;
        test_wrap;
        test_toggle;
        test_restart;
        test_async_reset;
        test_start_in_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/frame_scan_counter.md
FRAME_SCAN_COUNTER -- requirements
Module: frame_scan_counter

Interface
REQ-001 Parameter COL_BITS, default 11, width of column counter.
REQ-002 Parameter ROW_BITS, default 11, width of row counter.
REQ-003 Parameter WIDTH, default 1024, pixels per line; legal range 2*RADIUS+1 .. 2^COL_BITS.
REQ-004 Parameter HEIGHT, default 768, lines per frame; legal range 2*RADIUS+1 .. 2^ROW_BITS.
REQ-005 Parameter RADIUS, default 1, filter window radius for border flagging; 3x3 median uses 1.
REQ-006 Parameter WRAP, default 0; 0 = stop after one frame, 1 = free-running frame after frame.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  begin a frame scan from IDLE.
REQ-010 en_count  input  1  advance position by one pixel.
REQ-011 restart  input  1  synchronous abort: return to position 0,0 and IDLE.
REQ-012 col  output  COL_BITS  current column, registered.
REQ-013 row  output  ROW_BITS  current row, registered.
REQ-014 eol  output  1  current pixel is last of its line.
REQ-015 eof  output  1  current pixel is last of frame.
REQ-016 border  output  1  current pixel lies within RADIUS of any frame edge.
REQ-017 busy  output  1  state is RUN.
REQ-018 done  output  1  one-cycle pulse, frame completed.

Function
REQ-019 State machine states SHALL be IDLE and RUN; RUN is the only state in which the position advances.
REQ-020 IDLE with start=1 SHALL go to RUN next cycle, with col=0 and row=0.
REQ-021 start SHALL be ignored in RUN; en_count SHALL be ignored in IDLE.
REQ-022 RUN with en_count=1 and col<WIDTH-1 SHALL increment col by 1, row unchanged.
REQ-023 RUN with en_count=1, col=WIDTH-1 and row<HEIGHT-1 SHALL set col=0 and increment row by 1.
REQ-024 RUN with en_count=1 at col=WIDTH-1, row=HEIGHT-1 SHALL set col=0, row=0 and, if WRAP=0, go to IDLE; if WRAP=1, stay in RUN.
REQ-025 done SHALL be 1 for exactly the one cycle following the advance of REQ-024, in both WRAP modes, otherwise 0.
REQ-026 RUN with en_count=0 SHALL hold col and row.
REQ-027 restart=1 SHALL, in any state, set col=0, row=0, state=IDLE, done=0 next cycle; restart wins over start and en_count in the same cycle.
REQ-028 eol SHALL equal busy AND col==WIDTH-1, decoded from registered state with no input-to-output path.
REQ-029 eof SHALL equal eol AND row==HEIGHT-1.
REQ-030 border SHALL equal busy AND (col<RADIUS OR col>WIDTH-1-RADIUS OR row<RADIUS OR row>HEIGHT-1-RADIUS).
REQ-031 Counters SHALL never exceed WIDTH-1 or HEIGHT-1; no modulo-2^N wrap is permitted.
REQ-032 Comparison constants SHALL be evaluated at elaboration at widths COL_BITS and ROW_BITS without truncation.

Reset
REQ-033 rst_n=0 SHALL immediately, without clk, force state=IDLE, col=0, row=0, done=0, and therefore busy=eol=eof=border=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for start.
REQ-035 The first rising clk edge after rst_n release SHALL be the first edge with normal function.

Verification (WIDTH=4, HEIGHT=3, RADIUS=1)
REQ-036 Reset, start pulse, en_count held high 12 cycles, WRAP=0 -> col sequence 0,1,2,3 per row, row 0..2; eol at col=3; eof at (3,2); done one cycle after the 12th advance; busy=0 afterwards.
REQ-037 WRAP=1, en_count high 24 cycles -> two done pulses 12 cycles apart, busy stays 1, position returns to (0,0).
REQ-038 In RUN, en_count toggled 1,0,1 -> col 0->1->1->2; border=1 at (0,0), (1,0) and =0 at (1,1), (2,1).
REQ-039 At position (2,1), restart=1 together with en_count=1 and start=1 -> next cycle col=0, row=0, busy=0, done=0.
REQ-040 rst_n pulled low between clk edges at (3,1) -> outputs zero before next edge; en_count ignored until a new start.
REQ-041 start pulse while in RUN at (1,2) -> position unaffected, scan continues to eof.
